l2_word_responder: RTL

- Memory-side responder for the single-word L2 request interface driven by the dcache controller.
- Accepts one word request at a time: LOAD/STORE, word address, write data.
- Completes each request after a fixed, parameterised latency and signals completion with a one-cycle l2_req_fulfilled pulse.
- Contains a single-port word array as backing store. Serves as the L2 stand-in for cache integration and as a latency-programmable memory model.

---
 rtl/xentry_pkg.sv | 20 ++
 rtl/l2_word_sram.sv | 25 ++
 rtl/l2_word_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/xentry_pkg.sv
// Shared types for the dcache / L2 word interface and the L2 responder state machine.
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        STORE      = 2'd1,
        MO_UNKNOWN = 2'd2
    } memory_operation_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } l2_responder_state_e;

    function automatic logic is_known_op(input memory_operation_e op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/l2_word_sram.sv
// Single-port synchronous word array: one-cycle registered read, write-enable; read data holds between reads.
module l2_word_sram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/l2_word_responder.sv
// L2 stand-in: accepts one word request at a time and completes it after LATENCY cycles.
//
// state      | meaning
// ST_IDLE    | waiting for l2_req_valid; request fields sampled here only
// ST_WAIT    | counting down latency; valid drop aborts, stall freezes
// ST_RESPOND | one-cycle fulfilled pulse, always back to ST_IDLE
import xentry_pkg::*;

module l2_word_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l2_req_valid,
    input  memory_operation_e     l2_req_type,
    input  logic [ADDR_WIDTH-1:0] l2_req_address,
    input  logic [DATA_WIDTH-1:0] l2_req_wdata,
    input  logic                  stall,
    output logic                  l2_req_fulfilled,
    output logic [DATA_WIDTH-1:0] l2_rdata,
    output logic                  l2_req_error
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("l2_word_responder: LATENCY must be in 1..255");
    end

    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    l2_responder_state_e   state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    memory_operation_e     type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  rdata_zero;
    logic                  accept;
    logic                  enter_respond;

    memory_operation_e     op_type;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  sram_we;
    logic                  sram_re;

    // With LATENCY=1 the array is accessed on the accept edge, so use the live request fields in idle.
    assign op_type  = (state == ST_IDLE) ? l2_req_type    : type_q;
    assign op_addr  = (state == ST_IDLE) ? l2_req_address : addr_q;
    assign op_wdata = (state == ST_IDLE) ? l2_req_wdata   : wdata_q;
    assign sram_we  = enter_respond && !reset && (op_type == STORE);
    assign sram_re  = enter_respond && !reset && (op_type == LOAD);

    l2_word_sram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sram (
        .clk  (clk),
        .we   (sram_we),
        .re   (sram_re),
        .addr (op_addr),
        .wdata(op_wdata),
        .rdata(sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            type_q     <= LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_zero <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                type_q  <= l2_req_type;
                addr_q  <= l2_req_address;
                wdata_q <= l2_req_wdata;
            end
            if (enter_respond) begin
                err_q <= !is_known_op(op_type);
                if (op_type == LOAD) begin
                    rdata_zero <= 1'b0;
                end else if (op_type != STORE) begin
                    rdata_zero <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        accept           = 1'b0;
        enter_respond    = 1'b0;
        l2_req_fulfilled = 1'b0;
        l2_req_error     = 1'b0;
        l2_rdata         = rdata_zero ? '0 : sram_rdata;
        case (state)
            ST_IDLE: begin
                if (l2_req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt     = ST_RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!l2_req_valid) begin
                    state_nxt = ST_IDLE;
                end else if (!stall) begin
                    if (cnt == 8'd0) begin
                        state_nxt     = ST_RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            ST_RESPOND: begin
                l2_req_fulfilled = 1'b1;
                l2_req_error     = err_q;
                state_nxt        = ST_IDLE;
            end
            default: begin
                state_nxt        = ST_IDLE;
                l2_req_fulfilled = 1'bx;
                l2_req_error     = 1'bx;
                l2_rdata         = 'x;
            end
        endcase
    end

endmodule
